// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with a registered output and fixed or round-robin grant
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);
  logic [SEL_W-1:0] ptr, hi, lo, gnt;
  logic hi_v, lo_v, fix_v, gnt_v, load_en;
  // Lowest valid channel above ptr wins, else lowest valid at or below ptr: a cyclic search from ptr+1.
  always_comb begin
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi = '0;
    lo = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && i > int'(ptr)) begin
        hi_v = 1'b1;
        hi = SEL_W'(i);
      end else if (in_valid[i]) begin
        lo_v = 1'b1;
        lo = SEL_W'(i);
      end
    end
  end
  assign fix_v = (int'(select) < CHANNELS) && in_valid[select];
  assign gnt_v = mode ? (hi_v || lo_v) : fix_v;
  assign gnt = mode ? (hi_v ? hi : lo) : select;
  assign load_en = !out_valid || out_ready;
  assign in_ready = (load_en && gnt_v) ? CHANNELS'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      out_valid <= gnt_v;
      if (gnt_v) begin
        out_data <= in_data[int'(gnt)*WIDTH +: WIDTH];
        out_chan <= gnt;
        ptr <= gnt;
      end
    end
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer with valid/ready handshaking on every port and a registered output stage. It is the next step up from the team's combinational tree muxes. Width and channel count are generic. A mode input chooses between a fixed externally driven select and fair round-robin arbitration. It sits between multiple producer streams and a single downstream consumer. Channel identity travels with the data.

## Interface
- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2, any integer, not limited to powers of 2)
- SEL_W, derived, $clog2(CHANNELS); not overridable

- clk  in  1  rising-edge clock, the only clock in the block
- rst_n  in  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk
- mode  in  1  0 = fixed select, 1 = round-robin
- select  in  SEL_W  channel index used when mode=0
- in_valid  in  CHANNELS  per-channel valid
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  CHANNELS  per-channel ready; combinational
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered data
- out_chan  out  SEL_W  index of the channel that sourced out_data
- out_ready  in  1  downstream accepts when high with out_valid

## Operation
- Single output register stage: out_valid, out_data, out_chan. There is no other storage.
- load_en = !out_valid || out_ready. The register may load when empty or when being drained in the same cycle.
- Grant is at most one channel per cycle.
  - mode=0: the granted channel is select when select < CHANNELS and in_valid[select]=1. Otherwise there is no grant. An out-of-range select never grants.
  - mode=1: the granted channel is the first i with in_valid[i]=1, searched cyclically from ptr+1, ptr+2, … wrapping modulo CHANNELS up to and including ptr. If no channel is valid, there is no grant.
- in_ready[i] = load_en && (grant == i). All other bits are 0.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - ptr <= g, in both modes
- If load_en=1 and there is no grant: out_valid <= 0. out_data and out_chan hold their values.
- If load_en=0: the register holds and all in_ready are 0.
- ptr is internal, SEL_W bits, and only ever takes values 0..CHANNELS-1.
- Mode and select are sampled combinationally each cycle. Changing them never alters data already held in the output register.
- Producers must hold in_valid/in_data until the transfer. Once out_valid is asserted, the block holds out_valid/out_data/out_chan stable until out_ready.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_chan = 0
  - ptr = CHANNELS-1, so channel 0 has first priority after reset
  - in_ready = 0 for every channel with in_valid low
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle sustained while out_ready=1.
- Combinational paths:
  - out_ready -> in_ready
  - in_valid/mode/select -> in_ready
  - There is no path from any input to out_*.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old one on the same edge. There is no bubble.
- Reset mid-transfer: the held word is discarded and out_valid drops immediately, asynchronously. The first grant after reset follows the reset ptr.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0 with no channel repeated before every other channel has been served.
- Single valid channel in round-robin: it is granted every cycle, including back-to-back repeats.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data and out_chan go to 0 immediately. After release with in_valid=4'b1111 and mode=1, the first out_chan is 0.
- Fixed mode: CHANNELS=4, WIDTH=8, mode=0, select=2, in_data ch2=8'hA5, all valid, out_ready=1 -> in_ready=4'b0100. One cycle later out_data=8'hA5 and out_chan=2. The other channels are never accepted.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid high continuously from the 2nd cycle.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> in_ready=0000, out_data stable. With out_ready=1 on cycle 4, a same-cycle reload occurs and out_valid stays 1.
- Sparse/wrap: mode=1, ptr=2, in_valid=4'b0011 -> grant ch0, then ch1, then ch0. Then in_valid=0 with out_ready=1 -> out_valid=0 on the next edge.
- Non-power-of-2 and out-of-range select: CHANNELS=3, mode=0, select=3, in_valid=3'b111 -> in_ready=000 and out_valid stays 0. Switch to select=1 -> ch1 is granted on the same cycle.
